desserializa_hamming: RTL

- Receive-side stage that consumes the Hamming(15,11) codeword stream produced by the encoder/error-injector path, delivered one bit per valid cycle.
- Assembles 15 bits, computes the syndrome and corrects any single-bit error.
- Delivers the 11-bit data word downstream over a valid/ready handshake.
- Sits between the serial channel and the consumer of decoded data; replaces the purely combinational corrector in streaming use.

---
 rtl/hamming_pkg.sv | 25 ++
 rtl/corrige_hamming.sv | 42 ++++
 rtl/desserializa_hamming.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) definitions: widths, receiver FSM states and the
// codeword-position map of each data bit (common to encoder and correctors).
package hamming_pkg;

  localparam int DADOS    = 11;
  localparam int CODIGO   = 15;
  localparam int SINDROME = 4;

  typedef enum logic [1:0] {
    OCIOSO,
    RECEBE,
    CORRIGE,
    ENTREGA
  } estado_t;

  // Nibble i holds the codeword position (1..15) of data bit i.
  localparam logic [DADOS*4-1:0] POS_DADOS = {
    4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
  };

  function automatic int posicao_dado(input int i);
    return int'(POS_DADOS[4*i +: 4]);
  endfunction

endpackage

// File: rtl/corrige_hamming.sv
// Combinational Hamming(15,11) corrector: syndrome, single-bit flip and
// extraction of the 11 data bits from a parallel codeword.
module corrige_hamming
  import hamming_pkg::*;
(
  input  logic [CODIGO-1:0]   i_codigo,
  output logic [DADOS-1:0]    o_dados,
  output logic [SINDROME-1:0] o_sindrome,
  output logic                o_erro
);

  logic [SINDROME-1:0] w_sindrome;
  logic [CODIGO-1:0]   w_corrigido;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so the loop accumulates in order and no latch is inferred.
  always_comb begin
    w_sindrome = '0;
    for (int p = 1; p <= CODIGO; p++) begin
      if (i_codigo[p-1]) w_sindrome ^= SINDROME'(p);
    end
  end

  // A zero syndrome matches no position, so the word passes through untouched.
  always_comb begin
    w_corrigido = i_codigo;
    for (int p = 1; p <= CODIGO; p++) begin
      if (w_sindrome == SINDROME'(p)) w_corrigido[p-1] = ~i_codigo[p-1];
    end
  end

  always_comb begin
    o_dados = '0;
    for (int i = 0; i < DADOS; i++) begin
      o_dados[i] = w_corrigido[posicao_dado(i)-1];
    end
  end

  assign o_sindrome = w_sindrome;
  assign o_erro     = (w_sindrome != '0);

endmodule

// File: rtl/desserializa_hamming.sv
// Serial Hamming(15,11) receiver: assembles a codeword, corrects it and hands
// the data word downstream over valid/ready. Optional macro CONTA_ERROS_EN
// adds a saturating count of delivered corrected words (contador_erros).
module desserializa_hamming
  import hamming_pkg::*;
#(
  parameter int LIMITE_OCIOSO = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bit_entrada,
  input  logic                bit_valido,
  output logic                entrada_pronta,
  output logic [DADOS-1:0]    saida,
  output logic                saida_valida,
  input  logic                saida_pronta,
  output logic                erro_corrigido,
  output logic [SINDROME-1:0] sindrome,
  output logic                quadro_abortado
`ifdef CONTA_ERROS_EN
  ,
  output logic [15:0]         contador_erros
`endif
);

  estado_t             r_estado;
  estado_t             w_proximo;
  logic [CODIGO-1:0]   r_codigo;
  logic [3:0]          r_contador;
  logic [7:0]          r_ocioso;
  logic [DADOS-1:0]    r_saida;
  logic [SINDROME-1:0] r_sindrome;
  logic                r_erro;
  logic                r_valida;
  logic                r_abortado;

  logic                w_aceita;
  logic                w_timeout;
  logic                w_ultimo;
  logic                w_entrega;
  logic [DADOS-1:0]    w_dados;
  logic [SINDROME-1:0] w_sindrome;
  logic                w_erro;

  assign entrada_pronta = (r_estado == OCIOSO) || (r_estado == RECEBE);
  assign w_aceita       = bit_valido && entrada_pronta;
  assign w_ultimo       = w_aceita && (r_estado == RECEBE) &&
                          (r_contador == 4'(CODIGO - 1));
  // An accepted bit in the would-be timeout cycle keeps the frame alive.
  assign w_timeout      = (r_estado == RECEBE) && !w_aceita &&
                          (r_ocioso == 8'(LIMITE_OCIOSO - 1));
  assign w_entrega      = r_valida && saida_pronta;

  corrige_hamming u_corrige (
    .i_codigo   (r_codigo),
    .o_dados    (w_dados),
    .o_sindrome (w_sindrome),
    .o_erro     (w_erro)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= OCIOSO;
    else        r_estado <= w_proximo;
  end

  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      OCIOSO:  if (w_aceita) w_proximo = RECEBE;
      RECEBE: begin
        if (w_ultimo)       w_proximo = CORRIGE;
        else if (w_timeout) w_proximo = OCIOSO;
      end
      CORRIGE: w_proximo = ENTREGA;
      ENTREGA: if (w_entrega) w_proximo = OCIOSO;
      default: w_proximo = OCIOSO;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' only. The codeword register
  // is reset like the rest even though each frame rewrites all 15 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_codigo   <= '0;
      r_contador <= '0;
      r_ocioso   <= '0;
      r_saida    <= '0;
      r_sindrome <= '0;
      r_erro     <= 1'b0;
      r_valida   <= 1'b0;
      r_abortado <= 1'b0;
    end else begin
      r_abortado <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (w_aceita) begin
            r_codigo[0] <= bit_entrada;
            r_contador  <= 4'd1;
            r_ocioso    <= '0;
          end
        end
        RECEBE: begin
          if (w_aceita) begin
            r_codigo[r_contador] <= bit_entrada;
            r_contador           <= r_contador + 4'd1;
            r_ocioso             <= '0;
          end else if (w_timeout) begin
            r_abortado <= 1'b1;
            r_contador <= '0;
            r_ocioso   <= '0;
          end else begin
            r_ocioso <= r_ocioso + 8'd1;
          end
        end
        CORRIGE: begin
          r_saida    <= w_dados;
          r_sindrome <= w_sindrome;
          r_erro     <= w_erro;
          r_valida   <= 1'b1;
          r_contador <= '0;
        end
        ENTREGA: begin
          if (w_entrega) r_valida <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign saida           = r_saida;
  assign sindrome        = r_sindrome;
  assign erro_corrigido  = r_erro;
  assign saida_valida    = r_valida;
  assign quadro_abortado = r_abortado;

`ifdef CONTA_ERROS_EN
  logic [15:0] r_contador_erros;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_contador_erros <= '0;
    end else if (w_entrega && r_erro && (r_contador_erros != 16'hFFFF)) begin
      r_contador_erros <= r_contador_erros + 16'd1;
    end
  end

  assign contador_erros = r_contador_erros;
`endif

endmodule
